// File: rtl/alu_seq.sv
// alu_seq: WIDTH-generic multi-cycle integer ALU (add/sub/mul/div, signed or unsigned)
// with a start/busy/done handshake. Mul/div iterate on operand magnitudes, then sign-fix.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [1:0]       control,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] extra,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d, ext_q, ext_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       ctl_q, ctl_d;
  logic             sgn_q, sgn_d, negq_q, negq_d, nega_q, nega_d, done_q, done_d, dz_q, dz_d;

  logic             a_neg, b_neg, is_sub, as_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, b_as;
  logic [WIDTH:0]   as_sum, mul_sum, div_shl, div_dif;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_neg = signed_mode & op1[WIDTH-1];
  assign b_neg = signed_mode & op2[WIDTH-1];
  assign a_mag = a_neg ? -op1 : op1;
  assign b_mag = b_neg ? -op2 : op2;

  // sub is a + ~b + 1, so as_sum[WIDTH] is carry-out = no-borrow
  assign is_sub   = (ctl_q == OP_SUB);
  assign b_as     = is_sub ? ~b_q : b_q;
  assign as_sum   = {1'b0, a_q} + {1'b0, b_as} + {{WIDTH{1'b0}}, is_sub};
  assign as_ovf   = (a_q[WIDTH-1] == b_as[WIDTH-1]) && (as_sum[WIDTH-1] != a_q[WIDTH-1]);

  // {hi,lo} is the product register for mul and the {remainder,dividend/quotient} pair for div
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_shl  = {hi_q, lo_q[WIDTH-1]};
  assign div_dif  = div_shl - {1'b0, b_q};
  assign prod_neg = -{hi_q, lo_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    ext_d   = ext_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    nega_d  = nega_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_d    = op1;
        b_d    = control[1] ? b_mag : op2;
        ctl_d  = control;
        sgn_d  = signed_mode;
        negq_d = a_neg ^ b_neg;
        nega_d = a_neg;
        hi_d   = '0;
        lo_d   = a_mag;
        cnt_d  = CW'(WIDTH - 1);
        dz_d   = 1'b0;
        if (!control[1] || (control == OP_DIV && op2 == '0)) state_d = DONE;
        else                                                   state_d = RUN;
      end
      RUN: begin
        if (ctl_q == OP_MUL) begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_dif[WIDTH]) begin
          hi_d = div_dif[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shl[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        // truncating division: quotient sign = sign xor, remainder follows dividend
        if (ctl_q == OP_MUL) begin
          if (negq_q) {hi_d, lo_d} = prod_neg;
        end else begin
          if (negq_q) lo_d = -lo_q;
          if (nega_q) hi_d = -hi_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        case (ctl_q)
          OP_MUL: begin
            res_d = lo_q;
            ext_d = hi_q;
          end
          OP_DIV: begin
            if (b_q == '0) begin
              res_d = '1;
              ext_d = a_q;
              dz_d  = 1'b1;
            end else begin
              res_d = lo_q;
              ext_d = hi_q;
            end
          end
          default: begin
            res_d = as_sum[WIDTH-1:0];
            ext_d = {{(WIDTH-1){1'b0}}, sgn_q ? as_ovf : as_sum[WIDTH]};
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      ext_q   <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      nega_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      ext_q   <= ext_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      nega_q  <= nega_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign result   = res_q;
  assign extra    = ext_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32 and WIDTH=8: directed literal vectors, a cycle-level
// arithmetic reference model for the 32-bit instance, and corner-biased random operations.
`timescale 1ns/1ps
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, sm = 1'b0;
  logic [1:0]  ctl = 2'b00;
  logic [31:0] op1 = '0, op2 = '0;
  logic        busy, done, dz;
  logic [31:0] res, ext;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [1:0]  ctl8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  res8, ext8;

  int checks = 0, failures = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clock(clk), .reset(rst_n), .start(start), .op1(op1), .op2(op2), .control(ctl),
    .signed_mode(sm), .busy(busy), .done(done), .result(res), .extra(ext), .div_zero(dz));

  alu_seq #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst_n), .start(start8), .op1(a8), .op2(b8), .control(ctl8),
    .signed_mode(sm8), .busy(busy8), .done(done8), .result(res8), .extra(ext8), .div_zero(dz8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers for any width up to 32.
  function automatic void model_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] c, input logic s,
                                   output logic [63:0] r, output logic [63:0] e,
                                   output logic z, output int lat);
    longint mask, lim, sa, sb, p;
    mask = (longint'(1) <<< w) - 1;
    lim  = longint'(1) <<< (w - 1);
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (s && sa >= lim) sa = sa - 2 * lim;
    if (s && sb >= lim) sb = sb - 2 * lim;
    z = 1'b0;
    lat = 1;
    r = '0;
    e = '0;
    case (c)
      2'd0, 2'd1: begin
        p = (c == 2'd0) ? sa + sb : sa - sb;
        r = p & mask;
        if (s)              e = (p >= lim || p < -lim) ? 64'd1 : 64'd0;
        else if (c == 2'd0) e = (p > mask) ? 64'd1 : 64'd0;
        else                e = (p >= 0) ? 64'd1 : 64'd0;
      end
      2'd2: begin
        p = sa * sb;
        r = p & mask;
        e = (p >>> w) & mask;
        lat = w + 2;
      end
      default: begin
        if (sb == 0) begin
          r = mask;
          e = longint'(a) & mask;
          z = 1'b1;
        end else begin
          r = (sa / sb) & mask;
          e = (sa % sb) & mask;
          lat = w + 2;
        end
      end
    endcase
  endfunction

  // Cycle model of the 32-bit instance: what busy/done/result/extra/div_zero must be.
  logic [31:0] m_res = '0, m_ext = '0, p_res = '0, p_ext = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [63:0] r64, e64;
  int          m_cnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_ext = '0; m_dz = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_res = p_res; m_ext = p_ext; m_dz = p_dz;
        end
      end else if (start) begin
        model_op(32, {32'd0, op1}, {32'd0, op2}, ctl, sm, r64, e64, p_dz, m_cnt);
        p_res = r64[31:0];
        p_ext = e64[31:0];
        m_busy = 1'b1;
        m_dz = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy",     64'(busy), 64'(m_busy));
    chk("done",     64'(done), 64'(m_done));
    chk("result",   64'(res),  64'(m_res));
    chk("extra",    64'(ext),  64'(m_ext));
    chk("div_zero", 64'(dz),   64'(m_dz));
  end

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFF;
      3: return 8'h80;
      4: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                      input logic s, input bit lit, input logic [31:0] er,
                      input logic [31:0] ee, input logic edz, input int elat, input bit poke);
    int n;
    @(negedge clk);
    op1 = a; op2 = b; ctl = c; sm = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op1 = $urandom; op2 = $urandom; ctl = 2'($urandom); sm = ~s;
    n = 0;
    while (!done && n < 80) begin
      start = (poke && n == 4);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    if (lit) begin
      chk("lit_latency", 64'(n),   64'(elat));
      chk("lit_result",  64'(res), 64'(er));
      chk("lit_extra",   64'(ext), 64'(ee));
      chk("lit_div_zero", 64'(dz), 64'(edz));
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                     input logic s, input bit lit, input logic [7:0] er,
                     input logic [7:0] ee, input int elat);
    int n, lat;
    logic [63:0] r, e;
    logic z;
    model_op(8, {56'd0, a}, {56'd0, b}, c, s, r, e, z, lat);
    @(negedge clk);
    a8 = a; b8 = b; ctl8 = c; sm8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ctl8 = 2'($urandom);
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w8_done_seen", 64'(done8), 64'd1);
    chk("w8_latency",   64'(n),     64'(lat));
    chk("w8_result",    64'(res8),  r);
    chk("w8_extra",     64'(ext8),  e);
    chk("w8_div_zero",  64'(dz8),   64'(z));
    if (lit) begin
      chk("w8_lit_latency", 64'(n),    64'(elat));
      chk("w8_lit_result",  64'(res8), 64'(er));
      chk("w8_lit_extra",   64'(ext8), 64'(ee));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",   64'(busy), 64'd0);
    chk("reset_done",   64'(done), 64'd0);
    chk("reset_result", 64'(res),  64'd0);
    chk("reset_extra",  64'(ext),  64'd0);
    chk("reset_dz",     64'(dz),   64'd0);
    rst_n = 1'b1;

    op32(32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, 1, 32'h0,         32'h1,         1'b0, 1,  0);
    op32(32'h7FFF_FFFF, 32'h1, 2'b00, 1'b1, 1, 32'h8000_0000, 32'h1,         1'b0, 1,  0);
    op32(32'd5,         32'd7, 2'b01, 1'b0, 1, 32'hFFFF_FFFE, 32'h0,         1'b0, 1,  0);
    op32(32'h8000_0000, 32'h1, 2'b01, 1'b1, 1, 32'h7FFF_FFFF, 32'h1,         1'b0, 1,  0);
    op32(32'hFFFF_FFF9, 32'd6, 2'b10, 1'b1, 1, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0, 34, 1);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b0, 1, 32'h1, 32'hFFFF_FFFE, 1'b0, 34, 0);
    op32(32'hFFFF_FFF9, 32'd2, 2'b11, 1'b1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0);
    op32(32'd100,       32'd7, 2'b11, 1'b0, 1, 32'd14,        32'd2,         1'b0, 34, 0);
    op32(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 1'b1, 1, 32'h8000_0000, 32'h0, 1'b0, 34, 0);
    op32(32'd1234,      32'd0, 2'b11, 1'b0, 1, 32'hFFFF_FFFF, 32'd1234,      1'b1, 1,  0);
    op32(32'd2,         32'd3, 2'b00, 1'b0, 1, 32'd5,         32'd0,         1'b0, 1,  0);
    op32(32'hFFFF_FFF0, 32'd0, 2'b11, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1,  0);

    // start held high across an add: accepted again on the done cycle
    @(negedge clk);
    op1 = 32'd3; op2 = 32'd4; ctl = 2'b00; sm = 1'b0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done1", 64'(done), 64'd1);
    chk("b2b_res1",  64'(res),  64'd7);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", 64'(busy), 64'd1);
    chk("b2b_done2", 64'(done), 64'd0);
    @(negedge clk);
    chk("b2b_done3", 64'(done), 64'd1);

    // reset in the middle of a multiply
    op32(32'd9, 32'd9, 2'b10, 1'b0, 1, 32'd81, 32'd0, 1'b0, 34, 0);
    @(negedge clk);
    op1 = 32'd12345; op2 = 32'd678; ctl = 2'b10; sm = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy",   64'(busy), 64'd0);
    chk("midrst_done",   64'(done), 64'd0);
    chk("midrst_result", 64'(res),  64'd0);
    chk("midrst_extra",  64'(ext),  64'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_idle", 64'(busy), 64'd0);
    op32(32'd12345, 32'd678, 2'b10, 1'b0, 1, 32'd8369910, 32'd0, 1'b0, 34, 0);

    op8(8'h80, 8'h80, 2'b10, 1'b1, 1, 8'h00, 8'h40, 10);
    op8(8'h80, 8'hFF, 2'b11, 1'b1, 1, 8'h80, 8'h00, 10);
    op8(8'hFF, 8'h01, 2'b00, 1'b0, 1, 8'h00, 8'h01, 1);

    for (int i = 0; i < 150; i++)
      op32(pick32(), pick32(), 2'($urandom), 1'($urandom), 0, '0, '0, 1'b0, 0, 0);
    for (int i = 0; i < 150; i++)
      op8(pick8(), pick8(), 2'($urandom), 1'($urandom), 0, '0, '0, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
